// File: rtl/motion_pkg.sv
// Shared types and helpers for the encoder position/velocity path.
// Homing states, default widths and velocity saturation.
package motion_pkg;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_SEEK,
    HS_HOMED
  } homing_state_t;

  localparam int POS_WIDTH_DEFAULT = 32;
  localparam int VEL_WIDTH_DEFAULT = 16;

  function automatic longint sat_to_vel(
    input longint d,
    input int     vw
  );
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (vw - 1)) - 1;
    lo = -hi - 1;
    if (d > hi) return hi;
    if (d < lo) return lo;
    return d;
  endfunction

endpackage

// File: rtl/velocity_window.sv
// Counts signed encoder steps over a fixed window of clocks and
// publishes the saturated delta with a one-cycle valid strobe.
module velocity_window #(
  parameter int SAMPLE_CLKS = 50000,
  parameter int VEL_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        count_pulse,
  input  logic                        direction,
  output logic signed [VEL_WIDTH-1:0] velocity,
  output logic                        velocity_valid
);
  import motion_pkg::*;

  localparam int PW = POS_WIDTH_DEFAULT;
  localparam int CW = $clog2(SAMPLE_CLKS);
  localparam logic [CW-1:0] LAST = CW'(SAMPLE_CLKS - 1);
  localparam logic signed [PW-1:0] ONE = PW'(1);

  logic [CW-1:0]                cnt;
  logic signed [PW-1:0]         delta;
  logic signed [PW-1:0]         delta_n;
  logic signed [VEL_WIDTH-1:0]  vel_n;
  logic                         last;

  // delta_n already includes this cycle's pulse
  always_comb begin
    delta_n = delta;
    if (count_pulse)
      delta_n = direction ? delta + ONE : delta - ONE;
    last  = (cnt == LAST);
    vel_n = VEL_WIDTH'(sat_to_vel(longint'(delta_n), VEL_WIDTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt            <= '0;
      delta          <= '0;
      velocity       <= '0;
      velocity_valid <= 1'b0;
    end else begin
      velocity_valid <= last;
      if (last) begin
        cnt      <= '0;
        delta    <= '0;
        velocity <= vel_n;
      end else begin
        cnt   <= cnt + CW'(1);
        delta <= delta_n;
      end
    end
  end

endmodule

// File: rtl/encoder_position_counter.sv
// Absolute encoder position with index capture, homing and
// windowed velocity for the motion loop.
module encoder_position_counter
  import motion_pkg::*;
#(
  parameter int POS_WIDTH   = POS_WIDTH_DEFAULT,
  parameter int VEL_WIDTH   = VEL_WIDTH_DEFAULT,
  parameter int SAMPLE_CLKS = 50000
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        count_pulse,
  input  logic                        direction,
  input  logic                        index,
  input  logic                        home_req,
  input  logic                        clear_pos,
  output logic signed [POS_WIDTH-1:0] position,
  output logic signed [POS_WIDTH-1:0] index_position,
  output logic                        index_seen,
  output logic                        homing,
  output logic                        homed,
  output logic                        overflow,
  output logic signed [VEL_WIDTH-1:0] velocity,
  output logic                        velocity_valid
);

  localparam logic signed [POS_WIDTH-1:0] P_MAX =
    {1'b0, {(POS_WIDTH-1){1'b1}}};
  localparam logic signed [POS_WIDTH-1:0] P_MIN =
    {1'b1, {(POS_WIDTH-1){1'b0}}};
  localparam logic signed [POS_WIDTH-1:0] ONE = POS_WIDTH'(1);

  homing_state_t state;
  homing_state_t state_n;

  logic                        index_d;
  logic                        idx_rise;
  logic                        zero_evt;
  logic signed [POS_WIDTH-1:0] pos_n;
  logic signed [POS_WIDTH-1:0] ipos_n;
  logic                        ovf_n;
  logic                        seen_n;

  assign idx_rise = index & ~index_d;
  assign zero_evt = (state == HS_SEEK) & idx_rise;

  always_comb begin
    state_n = state;
    unique case (state)
      HS_IDLE:  if (home_req) state_n = HS_SEEK;
      HS_SEEK:  if (idx_rise) state_n = HS_HOMED;
      HS_HOMED: if (home_req) state_n = HS_SEEK;
      default:  state_n = HS_IDLE;
    endcase
  end

  // a pulse colliding with either zeroing source is dropped
  always_comb begin
    pos_n = position;
    ovf_n = overflow;
    if (clear_pos) begin
      pos_n = '0;
      ovf_n = 1'b0;
    end else if (zero_evt) begin
      pos_n = '0;
    end else if (count_pulse) begin
      if (direction) begin
        pos_n = position + ONE;
        if (position == P_MAX) ovf_n = 1'b1;
      end else begin
        pos_n = position - ONE;
        if (position == P_MIN) ovf_n = 1'b1;
      end
    end
  end

  always_comb begin
    ipos_n = index_position;
    seen_n = index_seen;
    if (clear_pos) begin
      seen_n = 1'b0;
      if (idx_rise) ipos_n = '0;
    end else if (zero_evt) begin
      ipos_n = '0;
      seen_n = 1'b1;
    end else if (idx_rise) begin
      ipos_n = position;
      seen_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= HS_IDLE;
      index_d        <= 1'b0;
      position       <= '0;
      index_position <= '0;
      index_seen     <= 1'b0;
      overflow       <= 1'b0;
      homing         <= 1'b0;
      homed          <= 1'b0;
    end else begin
      state          <= state_n;
      index_d        <= index;
      position       <= pos_n;
      index_position <= ipos_n;
      index_seen     <= seen_n;
      overflow       <= ovf_n;
      homing         <= (state_n == HS_SEEK);
      homed          <= (state_n == HS_HOMED);
    end
  end

  velocity_window #(
    .SAMPLE_CLKS(SAMPLE_CLKS),
    .VEL_WIDTH  (VEL_WIDTH)
  ) u_vel (
    .clk           (clk),
    .reset         (reset),
    .count_pulse   (count_pulse),
    .direction     (direction),
    .velocity      (velocity),
    .velocity_valid(velocity_valid)
  );

endmodule

// File: tb/tb_encoder_position_counter.sv
// Directed bench: table of position/homing vectors, then hand
// sequences for velocity windows, wrap and saturation.
module tb_encoder_position_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic cp, dir, idx, hreq, clr;
  logic signed [31:0] pos, ipos;
  logic seen, homing, homed, ovf;
  logic signed [15:0] vel;
  logic vv;

  logic s_cp, s_dir, s_clr;
  logic signed [7:0] s_pos, s_ipos;
  logic s_seen, s_homing, s_homed, s_ovf;
  logic signed [3:0] s_vel;
  logic s_vv;

  int n_cmp = 0;
  int n_bad = 0;

  encoder_position_counter #(
    .POS_WIDTH(32), .VEL_WIDTH(16), .SAMPLE_CLKS(10)
  ) dut (
    .clk(clk), .reset(reset),
    .count_pulse(cp), .direction(dir), .index(idx),
    .home_req(hreq), .clear_pos(clr),
    .position(pos), .index_position(ipos),
    .index_seen(seen), .homing(homing), .homed(homed),
    .overflow(ovf), .velocity(vel), .velocity_valid(vv)
  );

  encoder_position_counter #(
    .POS_WIDTH(8), .VEL_WIDTH(4), .SAMPLE_CLKS(40)
  ) dut_s (
    .clk(clk), .reset(reset),
    .count_pulse(s_cp), .direction(s_dir), .index(1'b0),
    .home_req(1'b0), .clear_pos(s_clr),
    .position(s_pos), .index_position(s_ipos),
    .index_seen(s_seen), .homing(s_homing), .homed(s_homed),
    .overflow(s_ovf), .velocity(s_vel), .velocity_valid(s_vv)
  );

  typedef struct {
    int rep;
    logic cp, dir, idx, hreq, clr;
    logic signed [31:0] e_pos, e_ipos;
    logic e_seen, e_homing, e_homed, e_ovf;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    int r, logic c, logic d, logic i, logic h, logic k,
    int p, int ip, logic s, logic hm, logic hd, logic ov
  );
    vec_t t;
    t.rep = r; t.cp = c; t.dir = d; t.idx = i;
    t.hreq = h; t.clr = k;
    t.e_pos = p; t.e_ipos = ip; t.e_seen = s;
    t.e_homing = hm; t.e_homed = hd; t.e_ovf = ov;
    tbl.push_back(t);
  endfunction

  task automatic check(
    input string name,
    input logic signed [63:0] act,
    input logic signed [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(
    input int n, input int exp, input string name
  );
    int got = 0;
    for (int k = 0; k < 200 && got < n; k++) begin
      @(posedge clk); #1;
      if (s_vv) got++;
    end
    if (got < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout, got %0d strobes need %0d",
               name, got, n);
    end else begin
      check(name, s_vel, exp);
    end
  endtask

  int exp_vel[3] = '{5, 0, -3};

  initial begin
    reset = 1'b1;
    {cp, dir, idx, hreq, clr} = '0;
    {s_cp, s_dir, s_clr} = '0;

    //   rep c d i h k  pos ipos s hm hd ov
    add(1,  1,1,0,0,0,   1, 0, 0,0,0,0);
    add(1,  1,1,0,0,0,   2, 0, 0,0,0,0);
    add(1,  1,1,0,0,0,   3, 0, 0,0,0,0);
    add(1,  1,1,0,0,0,   4, 0, 0,0,0,0);
    add(1,  1,1,0,0,0,   5, 0, 0,0,0,0);
    add(1,  1,0,0,0,0,   4, 0, 0,0,0,0);
    add(1,  1,0,0,0,0,   3, 0, 0,0,0,0);
    add(1,  0,0,0,0,0,   3, 0, 0,0,0,0);
    add(1,  1,1,0,0,1,   0, 0, 0,0,0,0);
    add(57, 1,1,0,0,0,  57, 0, 0,0,0,0);
    add(1,  1,1,1,0,0,  58,57, 1,0,0,0);
    add(1,  0,0,1,0,0,  58,57, 1,0,0,0);
    add(42, 1,1,0,0,0, 100,57, 1,0,0,0);
    add(1,  0,0,0,1,0, 100,57, 1,1,0,0);
    add(4,  1,1,0,0,0, 104,57, 1,1,0,0);
    add(1,  0,0,0,1,0, 104,57, 1,1,0,0);
    add(1,  0,0,1,0,0,   0, 0, 1,0,1,0);
    add(1,  1,1,0,0,0,   1, 0, 1,0,1,0);
    add(1,  1,0,1,0,0,   0, 1, 1,0,1,0);
    add(1,  0,0,0,0,1,   0, 1, 0,0,1,0);
    add(1,  1,1,1,0,1,   0, 0, 0,0,1,0);
    add(1,  0,0,0,1,0,   0, 0, 0,1,0,0);
    add(3,  1,1,0,0,0,   3, 0, 0,1,0,0);
    add(1,  0,0,0,0,1,   0, 0, 0,1,0,0);
    add(2,  1,1,0,0,0,   2, 0, 0,1,0,0);
    add(1,  0,0,1,0,1,   0, 0, 0,0,1,0);
    add(1,  0,0,0,1,0,   0, 0, 0,1,0,0);
    add(5,  1,1,0,0,0,   5, 0, 0,1,0,0);

    repeat (3) @(posedge clk);
    #1;
    check("rst_pos", pos, 0);
    check("rst_flags", {ipos, seen, homing, homed, ovf}, 0);
    check("rst_vel", {vel, vv}, 0);
    check("rst_small", {s_pos, s_ipos, s_seen, s_homing,
                        s_homed, s_ovf, s_vel, s_vv}, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      cp = tbl[i].cp; dir = tbl[i].dir; idx = tbl[i].idx;
      hreq = tbl[i].hreq; clr = tbl[i].clr;
      repeat (tbl[i].rep) @(posedge clk);
      #1;
      n_cmp++;
      if ({pos, ipos, seen, homing, homed, ovf} !==
          {tbl[i].e_pos, tbl[i].e_ipos, tbl[i].e_seen,
           tbl[i].e_homing, tbl[i].e_homed, tbl[i].e_ovf}) begin
        n_bad++;
        $display("FAIL vec%0d: got pos=%0d ipos=%0d seen=%b hm=%b hd=%b ov=%b expected pos=%0d ipos=%0d seen=%b hm=%b hd=%b ov=%b",
          i, pos, ipos, seen, homing, homed, ovf,
          tbl[i].e_pos, tbl[i].e_ipos, tbl[i].e_seen,
          tbl[i].e_homing, tbl[i].e_homed, tbl[i].e_ovf);
      end
    end

    // reset while seeking the index
    {cp, dir, idx, hreq, clr} = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst_seek_homing", homing, 0);
    check("rst_seek_homed", homed, 0);
    check("rst_seek_pos", pos, 0);
    reset = 1'b0;

    // three velocity windows of 10 clocks
    for (int e = 1; e <= 30; e++) begin
      cp = 1'b0; dir = 1'b1;
      if (e <= 6 || e == 10) cp = 1'b1;
      if (e == 8 || e == 9) begin cp = 1'b1; dir = 1'b0; end
      if (e >= 21 && e <= 23) begin cp = 1'b1; dir = 1'b0; end
      @(posedge clk); #1;
      check($sformatf("vv_e%0d", e), vv, (e % 10 == 0));
      if (vv)
        check($sformatf("vel_e%0d", e), vel, exp_vel[e/10-1]);
    end
    cp = 1'b0;

    // narrow instance: wrap, clear and saturation
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    s_cp = 1'b1; s_dir = 1'b1;
    repeat (127) @(posedge clk);
    #1;
    check("s_pos_max", s_pos, 127);
    check("s_ovf_pre", s_ovf, 0);
    @(posedge clk); #1;
    check("s_pos_wrap", s_pos, -128);
    check("s_ovf_wrap", s_ovf, 1);
    s_cp = 1'b0; s_clr = 1'b1;
    @(posedge clk); #1;
    s_clr = 1'b0;
    check("s_pos_clr", s_pos, 0);
    check("s_ovf_clr", s_ovf, 0);
    s_cp = 1'b1; s_dir = 1'b1;
    wait_valid(2, 7, "s_vel_sat_hi");
    s_dir = 1'b0;
    wait_valid(2, -8, "s_vel_sat_lo");
    s_cp = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
